// File: rtl/i2c_txn_sequencer.sv
// Transaction sequencer for the single-master I2C controller: turns command-FIFO
// descriptors into START/address/data/STOP byte-engine operations and fills the RX FIFO.
module i2c_txn_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cmd_empty,
  input  logic [7:0] cmd_data,
  output logic       cmd_rd,
  input  logic       rx_full,
  output logic       rx_wr,
  output logic [7:0] rx_data,
  output logic       eng_valid,
  output logic [1:0] eng_op,
  output logic [7:0] eng_wdata,
  output logic       eng_last,
  input  logic       eng_ready,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  input  logic       eng_nack,
  output logic       busy,
  output logic       txn_done,
  output logic       txn_nack
);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;
  localparam logic [LEN_W:0] LEFT_ZERO = '0;
  localparam logic [LEN_W:0] LEFT_ONE  = {{LEN_W{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, LEN, START, WAIT_S, ADDR, WAIT_A, WR, WAIT_W,
    RD, WAIT_R, STOP, WAIT_P, FLUSH
  } state_t;

  state_t         state_reg, state_next;
  logic [LEN_W:0] left_reg, left_next;
  logic [7:0]     hdr_reg;
  logic           nack_reg;
  logic           accept;
  logic           start_ok;
  logic           to_idle;

  // Qualified with rst_n so the command FIFO is never popped while held in reset.
  assign start_ok = enable && !cmd_empty && rst_n;
  assign accept   = eng_valid && eng_ready;
  assign to_idle  = (state_reg != IDLE) && (state_next == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_ok)   state_next = LEN;
      LEN:     if (!cmd_empty) state_next = START;
      START:   if (accept)     state_next = WAIT_S;
      WAIT_S:  if (eng_done)   state_next = ADDR;
      ADDR:    if (accept)     state_next = WAIT_A;
      WAIT_A:  if (eng_done)   state_next = eng_nack ? STOP : (hdr_reg[0] ? RD : WR);
      WR:      if (accept)     state_next = WAIT_W;
      WAIT_W:  if (eng_done)   state_next = (eng_nack || left_reg == LEFT_ZERO) ? STOP : WR;
      RD:      if (accept)     state_next = WAIT_R;
      WAIT_R:  if (eng_done)   state_next = (left_reg == LEFT_ZERO) ? STOP : RD;
      STOP:    if (accept)     state_next = WAIT_P;
      WAIT_P:  if (eng_done)
                 state_next = (nack_reg && !hdr_reg[0] && left_reg != LEFT_ZERO) ? FLUSH : IDLE;
      FLUSH:   if (left_reg == LEFT_ZERO || (cmd_rd && left_reg == LEFT_ONE)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    eng_valid = 1'b0;
    eng_op    = OP_START;
    eng_wdata = 8'h00;
    eng_last  = 1'b0;
    cmd_rd    = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      IDLE:  cmd_rd = start_ok;
      LEN:   cmd_rd = !cmd_empty;
      START: eng_valid = 1'b1;
      ADDR: begin
        eng_valid = 1'b1;
        eng_op    = OP_WRITE;
        eng_wdata = hdr_reg;
      end
      // Payload word is popped in the same cycle the engine takes it.
      WR: begin
        eng_valid = !cmd_empty;
        eng_op    = OP_WRITE;
        eng_wdata = cmd_data;
        cmd_rd    = !cmd_empty && eng_ready;
      end
      RD: begin
        eng_valid = !rx_full;
        eng_op    = OP_READ;
        eng_last  = (left_reg == LEFT_ONE);
      end
      STOP: begin
        eng_valid = 1'b1;
        eng_op    = OP_STOP;
      end
      FLUSH:   cmd_rd = !cmd_empty && (left_reg != LEFT_ZERO);
      default: ;
    endcase
  end

  always_comb begin
    left_next = left_reg;
    if (state_reg == LEN && !cmd_empty)
      left_next = {1'b0, cmd_data[LEN_W-1:0]} + LEFT_ONE;
    else if (((state_reg == WR || state_reg == FLUSH) && cmd_rd) || (state_reg == RD && accept))
      left_next = left_reg - LEFT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_reg <= LEFT_ZERO;
      hdr_reg  <= 8'h00;
      nack_reg <= 1'b0;
      rx_wr    <= 1'b0;
      rx_data  <= 8'h00;
      txn_done <= 1'b0;
      txn_nack <= 1'b0;
    end else begin
      left_reg <= left_next;
      if (state_reg == IDLE && cmd_rd)
        hdr_reg <= cmd_data;
      rx_wr <= (state_reg == WAIT_R) && eng_done;
      if (state_reg == WAIT_R && eng_done)
        rx_data <= eng_rdata;
      txn_done <= to_idle;
      txn_nack <= to_idle && nack_reg;
      if (to_idle)
        nack_reg <= 1'b0;
      else if ((state_reg == WAIT_A || state_reg == WAIT_W) && eng_done && eng_nack)
        nack_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: FIFO and byte-engine models driven cycle by cycle, with
// expected operation streams derived from each descriptor.
module tb_i2c_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, enable, cmd_empty, cmd_rd, rx_full, rx_wr;
  logic [7:0] cmd_data, rx_data, eng_wdata, eng_rdata;
  logic       eng_valid, eng_last, eng_ready, eng_done, eng_nack;
  logic [1:0] eng_op;
  logic       busy, txn_done, txn_nack;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmd_empty(cmd_empty), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
    .rx_full(rx_full), .rx_wr(rx_wr), .rx_data(rx_data),
    .eng_valid(eng_valid), .eng_op(eng_op), .eng_wdata(eng_wdata), .eng_last(eng_last),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_rdata(eng_rdata), .eng_nack(eng_nack),
    .busy(busy), .txn_done(txn_done), .txn_nack(txn_nack)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  cmdq[$], feedq[$], payload[$], rd_exp[$], rx_got[$];
  logic [10:0] ops_exp[$], ops_got[$];
  int   pops, cyc, first_pop, first_val, nack_at, wr_idx, exp_pops, rdy_lo, rx_hold, eng_cnt;
  bit   exp_nack, trickle, stall_rdy, stall_rx, rdy_fired, rx_fired, eng_busy, pend;
  bit   got_done, got_nack, busy_at_done, empty_at_done, last_busy;
  logic [1:0]  eng_cur;
  logic [10:0] pend_rec;
  logic [6:0]  cur_addr;
  logic        cur_rw;
  logic [7:0]  cur_len;

  // Operation record: opcode, write byte (WRITE only), final-byte flag (READ only).
  function automatic logic [10:0] rec(input logic [1:0] op, input logic [7:0] d, input logic l);
    return {op, (op == 2'd1) ? d : 8'h00, (op == 2'd2) ? l : 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    cmd_empty = (cmdq.size() == 0);
    cmd_data  = cmd_empty ? 8'h00 : cmdq[0];
  endtask

  // One clock: sample at the falling edge, then update the environment just after the rising edge.
  task automatic tick();
    logic s_rd, s_empty, s_val, s_rdy, s_last, s_rxfull, s_rxwr, s_tdone, s_tnack;
    logic [1:0] s_op;
    logic [7:0] s_wd, s_rxd;
    @(negedge clk);
    s_rd = cmd_rd;  s_empty = cmd_empty; s_val = eng_valid; s_rdy = eng_ready;
    s_op = eng_op;  s_wd = eng_wdata;    s_last = eng_last; s_rxfull = rx_full;
    s_rxwr = rx_wr; s_rxd = rx_data;     s_tdone = txn_done; s_tnack = txn_nack;
    last_busy = busy;
    if (pend) chk("op_held_until_accept", 32'({s_val, rec(s_op, s_wd, s_last)}), 32'({1'b1, pend_rec}));
    pend = s_val && !s_rdy;
    pend_rec = rec(s_op, s_wd, s_last);
    if (s_rd) begin
      chk("pop_only_when_nonempty", 32'(s_empty), 32'd0);
      if (pops == 0) first_pop = cyc;
      pops++;
    end
    if (s_val && first_val < 0) first_val = cyc;
    if (s_val && s_rdy && s_op == 2'd2) chk("read_not_while_rx_full", 32'(s_rxfull), 32'd0);
    if (s_rxwr) rx_got.push_back(s_rxd);
    if (s_tnack) chk("txn_nack_with_done", 32'(s_tdone), 32'd1);
    if (s_tdone && !got_done) begin
      got_done = 1'b1; got_nack = s_tnack; busy_at_done = busy; empty_at_done = s_empty;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (s_rd && cmdq.size() > 0) void'(cmdq.pop_front());
    if (feedq.size() > 0 && (!trickle || $urandom_range(0, 1) == 1)) cmdq.push_back(feedq.pop_front());
    eng_done = 1'b0;
    eng_nack = 1'($urandom_range(0, 1));
    if (s_val && s_rdy) begin
      chk("one_op_outstanding", 32'(eng_busy), 32'd0);
      ops_got.push_back(rec(s_op, s_wd, s_last));
      eng_busy = 1'b1; eng_cnt = $urandom_range(0, 2); eng_cur = s_op;
    end
    if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_busy = 1'b0; eng_done = 1'b1;
        if (eng_cur == 2'd2) begin
          eng_rdata = 8'($urandom);
          rd_exp.push_back(eng_rdata);
        end
        if (eng_cur == 2'd1) begin
          eng_nack = (wr_idx == nack_at);
          wr_idx++;
        end
      end else eng_cnt--;
    end
    if (stall_rdy && !rdy_fired && ops_got.size() == 2) begin rdy_lo = 5; rdy_fired = 1'b1; end
    if (rdy_lo > 0) begin eng_ready = 1'b0; rdy_lo--; end
    else eng_ready = ($urandom_range(0, 3) != 0);
    if (stall_rx && !rx_fired && ops_got.size() == 3) begin rx_hold = 10; rx_fired = 1'b1; end
    if (rx_hold > 0) begin rx_full = 1'b1; rx_hold--; end
    else rx_full = 1'b0;
    refresh();
  endtask

  // nk: index of the WRITE to NACK (0 = address byte, k = k-th payload byte), -1 for none.
  task automatic load_txn(input logic [6:0] addr, input logic rw, input logic [7:0] len,
                          input int nk, input bit trk, input bit srdy, input bit srx);
    int n;
    n = int'(len) + 1;
    cur_addr = addr; cur_rw = rw; cur_len = len;
    ops_exp.delete(); ops_got.delete(); rd_exp.delete(); rx_got.delete(); payload.delete();
    pops = 0; first_pop = -1; first_val = -1; wr_idx = 0; nack_at = nk;
    trickle = trk; stall_rdy = srdy; stall_rx = srx; rdy_fired = 1'b0; rx_fired = 1'b0;
    got_done = 1'b0; got_nack = 1'b0; busy_at_done = 1'b0; empty_at_done = 1'b0;
    if (!rw) for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    cmdq.push_back({addr, rw});
    cmdq.push_back(len);
    foreach (payload[i]) begin
      if (trk) feedq.push_back(payload[i]);
      else     cmdq.push_back(payload[i]);
    end
    ops_exp.push_back(rec(2'd0, 8'h00, 1'b0));
    ops_exp.push_back(rec(2'd1, {addr, rw}, 1'b0));
    if (nk != 0) begin
      for (int i = 0; i < n; i++) begin
        if (rw) ops_exp.push_back(rec(2'd2, 8'h00, i == n - 1));
        else begin
          ops_exp.push_back(rec(2'd1, payload[i], 1'b0));
          if (nk == i + 1) break;
        end
      end
    end
    ops_exp.push_back(rec(2'd3, 8'h00, 1'b0));
    exp_pops = rw ? 2 : 2 + n;
    exp_nack = rw ? (nk == 0) : (nk >= 0 && nk <= n);
    refresh();
  endtask

  task automatic finish_txn(input int budget);
    logic [10:0] g;
    for (int i = 0; i < budget && !got_done; i++) tick();
    chk("txn_done_seen", 32'(got_done), 32'd1);
    chk("txn_nack", 32'(got_nack), 32'(exp_nack));
    chk("busy_low_at_done", 32'(busy_at_done), 32'd0);
    chk("cmd_empty_at_done", 32'(empty_at_done), 32'd1);
    chk("cmd_pops", 32'(pops), 32'(exp_pops));
    chk("op_count", 32'(ops_got.size()), 32'(ops_exp.size()));
    foreach (ops_exp[i]) begin
      g = (i < ops_got.size()) ? ops_got[i] : 11'h7FF;
      chk($sformatf("op%0d", i), 32'(g), 32'(ops_exp[i]));
    end
    chk("rx_count", 32'(rx_got.size()), 32'(rd_exp.size()));
    foreach (rd_exp[i]) chk($sformatf("rx%0d", i), 32'((i < rx_got.size()) ? rx_got[i] : 8'hxx), 32'(rd_exp[i]));
    $display("txn addr=0x%02h rw=%0d len=%0d ops=%0d pops=%0d rx=%0d nack=%0d",
             cur_addr, cur_rw, cur_len, ops_got.size(), pops, rx_got.size(), got_nack);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; rx_full = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
    eng_rdata = 8'h00; eng_nack = 1'b0; eng_busy = 1'b0; eng_cnt = 0; eng_cur = 2'd0;
    pend = 1'b0; pend_rec = '0; rdy_lo = 0; rx_hold = 0; cyc = 0; trickle = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({cmd_rd, rx_wr, rx_data, eng_valid, eng_op, eng_wdata,
                              eng_last, busy, txn_done, txn_nack}), 32'd0);
    rst_n = 1'b1; enable = 1'b1;
    @(posedge clk);
    #1;

    load_txn(7'h50, 1'b0, 8'd1, -1, 1'b0, 1'b0, 1'b0);   // plain two-byte write
    finish_txn(500);
    chk("fastest_start_latency", 32'(first_val - first_pop), 32'd2);
    load_txn(7'h50, 1'b1, 8'd2, -1, 1'b0, 1'b0, 1'b0);   // three-byte read
    finish_txn(500);
    load_txn(7'h33, 1'b0, 8'd3, 0, 1'b1, 1'b0, 1'b0);    // address NACK, payload flushed
    finish_txn(500);
    load_txn(7'h21, 1'b0, 8'd4, -1, 1'b1, 1'b1, 1'b0);   // next descriptor, engine stall
    finish_txn(500);
    load_txn(7'h12, 1'b0, 8'd3, 2, 1'b0, 1'b0, 1'b0);    // NACK on 2nd of 4 bytes
    finish_txn(500);
    load_txn(7'h45, 1'b1, 8'd4, -1, 1'b0, 1'b0, 1'b1);   // read with RX FIFO full
    finish_txn(500);
    load_txn(7'h46, 1'b1, 8'd5, 0, 1'b0, 1'b0, 1'b0);    // read address NACK
    finish_txn(500);
    load_txn(7'h47, 1'b0, 8'd2, 3, 1'b1, 1'b0, 1'b0);    // NACK on final byte, nothing left
    finish_txn(500);

    enable = 1'b0;
    load_txn(7'h55, 1'b0, 8'd0, -1, 1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    chk("enable_low_no_pop", 32'(pops), 32'd0);
    chk("enable_low_not_busy", 32'(last_busy), 32'd0);
    enable = 1'b1;
    finish_txn(500);

    load_txn(7'h2A, 1'b0, 8'd3, -1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300 && ops_got.size() < 3; i++) tick();
    chk("reached_wait_w", 32'(ops_got.size()), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({cmd_rd, rx_wr, rx_data, eng_valid, eng_op, eng_wdata,
                                    eng_last, busy, txn_done, txn_nack}), 32'd0);
    cmdq.delete(); feedq.delete(); eng_busy = 1'b0; eng_done = 1'b0; pend = 1'b0;
    rx_hold = 0; rx_full = 1'b0; rdy_lo = 0;
    refresh();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_txn(7'h3C, 1'b0, 8'd2, -1, 1'b0, 1'b0, 1'b0);
    finish_txn(500);

    load_txn(7'h7F, 1'b1, 8'hFF, -1, 1'b0, 1'b0, 1'b0);  // 256-byte read, 9-bit counter
    finish_txn(4000);

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1)
        load_txn(7'($urandom), 1'b1, 8'(n), ($urandom_range(0, 4) == 0) ? 0 : -1,
                 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        load_txn(7'($urandom), 1'b0, 8'(n),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n + 1)) : -1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      finish_txn(1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
